// File: rtl/clk_edge_monitor.sv
// rtl/clk_edge_monitor.sv - multi-channel rising-edge counter over a programmable window of clock cycles
// Optional range check against exp_lo/exp_hi is built when CLK_EDGE_MONITOR_CHECK_EN is defined.
module clk_edge_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       mon_in,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    continuous,
    input  logic [WIN_W-1:0]        window_len,
`ifdef CLK_EDGE_MONITOR_CHECK_EN
    input  logic [CNT_W-1:0]        exp_lo,
    input  logic [CNT_W-1:0]        exp_hi,
    output logic [NUM_CH-1:0]       fail,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*CNT_W-1:0] counts,
    output logic [NUM_CH-1:0]       ovf
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] ONES = '1;

    state_t                          state_q, state_n;
    logic [NUM_CH-1:0]               s1_q, s2_q, s3_q, rise;
    logic [NUM_CH-1:0][CNT_W-1:0]    acc_q, acc_n, load_cnt, counts_q;
    logic [NUM_CH-1:0]               sat_q, sat_n, load_ovf, ovf_q;
    logic [WIN_W-1:0]                rem_q;
    logic                            cont_q, done_q;
    logic                            accept, win_last, count_en, zero_start, load_en;

    // Synchronisers run regardless of FSM state so a window never starts on stale history.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= mon_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise       = s2_q & ~s3_q;
    assign accept     = (state_q == IDLE) && start && !abort;
    assign zero_start = accept && (window_len == '0);
    // rem_q==0 only occurs for a zero-length continuous reload: that window ends at once, empty.
    assign win_last   = (state_q == COUNT) && (rem_q <= WIN_W'(1));
    assign count_en   = (state_q == COUNT) && (rem_q != '0);
    assign load_en    = !abort && (zero_start || win_last);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept && ((window_len != '0) || continuous)) state_n = COUNT;
            COUNT:   if (win_last && !cont_q) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_comb begin
        busy = (state_q == COUNT);
    end

    // A rise arriving while the counter is already all-ones is a lost edge: hold and flag it.
    always_comb begin
        acc_n = acc_q;
        sat_n = sat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (count_en && rise[i]) begin
                if (acc_q[i] == ONES) sat_n[i] = 1'b1;
                else                  acc_n[i] = acc_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        load_cnt = acc_n;
        load_ovf = sat_n;
        if (zero_start) begin
            load_cnt = '0;
            load_ovf = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            sat_q    <= '0;
            counts_q <= '0;
            ovf_q    <= '0;
            rem_q    <= '0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= load_en;
            if (load_en) begin
                counts_q <= load_cnt;
                ovf_q    <= load_ovf;
            end
            // Clearing on the last cycle lets rises in the done cycle land in the next window.
            if (abort || accept || win_last) begin
                acc_q <= '0;
                sat_q <= '0;
            end else begin
                acc_q <= acc_n;
                sat_q <= sat_n;
            end
            if (accept) begin
                rem_q  <= window_len;
                cont_q <= continuous;
            end else if (win_last) begin
                rem_q <= window_len;
            end else if (state_q == COUNT) begin
                rem_q <= rem_q - WIN_W'(1);
            end
        end
    end

`ifdef CLK_EDGE_MONITOR_CHECK_EN
    logic [NUM_CH-1:0] fail_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fail_q <= '0;
        end else if (load_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fail_q[i] <= (load_cnt[i] < exp_lo) | (load_cnt[i] > exp_hi) | load_ovf[i];
            end
        end
    end

    assign fail = fail_q;
`endif

    assign done   = done_q;
    assign counts = counts_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb/tb_clk_edge_monitor.sv - directed self-checking bench for clk_edge_monitor
module tb_clk_edge_monitor;

    logic        clock = 1'b0;
    logic        reset, start, abort, continuous;
    logic [15:0] window_len;
    logic [1:0]  mon_in;
    logic        busy, done;
    logic [31:0] counts;
    logic [1:0]  ovf;

    logic        sat_start;
    logic [15:0] sat_len;
    logic [1:0]  sat_mon;
    logic        sat_busy, sat_done;
    logic [7:0]  sat_counts;
    logic [1:0]  sat_ovf;

`ifdef CLK_EDGE_MONITOR_CHECK_EN
    logic [15:0] exp_lo, exp_hi;
    logic [3:0]  sat_exp_lo, sat_exp_hi;
    logic [1:0]  fail, sat_fail;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hp[4] = '{0, 0, 0, 0};
    int ph[4] = '{0, 0, 0, 0};
    logic [3:0] sig = 4'b0000;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    clk_edge_monitor #(.NUM_CH(2), .CNT_W(16), .WIN_W(16)) dut (
        .clock(clock), .reset(reset), .mon_in(mon_in), .start(start), .abort(abort),
        .continuous(continuous), .window_len(window_len),
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        .exp_lo(exp_lo), .exp_hi(exp_hi), .fail(fail),
`endif
        .busy(busy), .done(done), .counts(counts), .ovf(ovf)
    );

    clk_edge_monitor #(.NUM_CH(2), .CNT_W(4), .WIN_W(16)) dut_sat (
        .clock(clock), .reset(reset), .mon_in(sat_mon), .start(sat_start), .abort(1'b0),
        .continuous(1'b0), .window_len(sat_len),
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        .exp_lo(sat_exp_lo), .exp_hi(sat_exp_hi), .fail(sat_fail),
`endif
        .busy(sat_busy), .done(sat_done), .counts(sat_counts), .ovf(sat_ovf)
    );

    // Square-wave sources: hp[j] is the half period in clock cycles, 0 holds the line low.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            for (int j = 0; j < 4; j++) begin
                if (hp[j] == 0) begin
                    sig[j] = 1'b0;
                end else begin
                    ph[j] = ph[j] + 1;
                    if (ph[j] >= hp[j]) begin
                        ph[j] = 0;
                        sig[j] = ~sig[j];
                    end
                end
            end
        end
    end

    assign mon_in  = sig[1:0];
    assign sat_mon = sig[3:2];

    task automatic pulse_start(input bit sel, output int t);
        @(posedge clock);
        #1;
        if (sel) sat_start = 1'b1;
        else     start = 1'b1;
        @(negedge clock);
        t = cyc;
        @(posedge clock);
        #1;
        sat_start = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int maxc, output int dc, output bit ok);
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if ((sel ? sat_done : done) === 1'b1) begin
                dc = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (counts !== 32'd0) begin errors++; $display("FAIL reset_counts: got %h expected 0", counts); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", ovf); end
        checks++; if (sat_counts !== 8'd0) begin errors++; $display("FAIL reset_sat_counts: got %h expected 0", sat_counts); end
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        checks++; if (fail !== 2'b00) begin errors++; $display("FAIL reset_fail: got %b expected 00", fail); end
`endif
    endtask

    task automatic test_single_shot();
        int t, dc;
        bit ok;
        hp[0] = 2;
        hp[1] = 3;
        repeat (10) @(posedge clock);
        window_len = 16'd512;
        continuous = 1'b0;
        pulse_start(1'b0, t);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        wait_done(1'b0, 600, dc, ok);
        checks++; if (dc - t != 513) begin errors++; $display("FAIL single_done_latency: got %0d expected 513", dc - t); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        checks++; if (counts[15:0] < 16'd127 || counts[15:0] > 16'd129) begin errors++; $display("FAIL single_ch0: got %0d expected 127..129", counts[15:0]); end
        checks++; if (counts[31:16] < 16'd84 || counts[31:16] > 16'd86) begin errors++; $display("FAIL single_ch1: got %0d expected 84..86", counts[31:16]); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL single_ovf: got %b expected 00", ovf); end
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        checks++; if (fail !== 2'b10) begin errors++; $display("FAIL check_range: got %b expected 10", fail); end
`endif
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
    endtask

    task automatic test_abort();
        int t, dc;
        bit ok;
        window_len = 16'd100;
        pulse_start(1'b0, t);
        repeat (49) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        wait_done(1'b0, 120, dc, ok);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done at %0d expected none", dc); end
        checks++; if (counts[15:0] < 16'd127 || counts[15:0] > 16'd129) begin errors++; $display("FAIL abort_keep_ch0: got %0d expected 127..129", counts[15:0]); end
        checks++; if (counts[31:16] < 16'd84 || counts[31:16] > 16'd86) begin errors++; $display("FAIL abort_keep_ch1: got %0d expected 84..86", counts[31:16]); end
        @(posedge clock);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
        wait_done(1'b0, 120, dc, ok);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL start_abort_no_done: got done at %0d expected none", dc); end
    endtask

    task automatic test_zero_len();
        int t;
        window_len = 16'd0;
        pulse_start(1'b0, t);
        @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1 at start+1", done); end
        checks++; if (counts !== 32'd0) begin errors++; $display("FAIL zero_counts: got %h expected 0", counts); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL zero_ovf: got %b expected 00", ovf); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
    endtask

    task automatic test_start_while_busy();
        int t, t2, dc;
        bit ok;
        window_len = 16'd100;
        pulse_start(1'b0, t);
        repeat (8) @(posedge clock);
        window_len = 16'd20;
        pulse_start(1'b0, t2);
        wait_done(1'b0, 200, dc, ok);
        checks++; if (dc - t != 101) begin errors++; $display("FAIL busy_start_latency: got %0d expected 101", dc - t); end
        checks++; if (counts[15:0] < 16'd24 || counts[15:0] > 16'd26) begin errors++; $display("FAIL busy_start_ch0: got %0d expected 24..26", counts[15:0]); end
    endtask

    task automatic test_continuous();
        int t, dc, prev, sum;
        bit ok;
        sum = 0;
        window_len = 16'd256;
        continuous = 1'b1;
        pulse_start(1'b0, t);
        continuous = 1'b0;
        prev = t - 1;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, 300, dc, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cont_done_%0d: got none expected pulse", k); end
            checks++; if (dc - prev != ((k == 0) ? 258 : 256)) begin errors++; $display("FAIL cont_spacing_%0d: got %0d expected %0d", k, dc - prev, (k == 0) ? 258 : 256); end
            checks++; if (counts[15:0] < 16'd63 || counts[15:0] > 16'd65) begin errors++; $display("FAIL cont_ch0_%0d: got %0d expected 63..65", k, counts[15:0]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_%0d: got %b expected 1", k, busy); end
            sum = sum + int'(counts[15:0]);
            prev = dc;
        end
        checks++; if (sum < 255 || sum > 257) begin errors++; $display("FAIL cont_sum: got %0d expected 255..257", sum); end
        @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy: got %b expected 0", busy); end
    endtask

    task automatic test_saturation();
        int t, dc;
        bit ok;
        hp[2] = 1;
        hp[3] = 0;
        repeat (6) @(posedge clock);
        sat_len = 16'd64;
        pulse_start(1'b1, t);
        wait_done(1'b1, 100, dc, ok);
        checks++; if (dc - t != 65) begin errors++; $display("FAIL sat_latency: got %0d expected 65", dc - t); end
        checks++; if (sat_counts[3:0] !== 4'd15) begin errors++; $display("FAIL sat_ch0: got %0d expected 15", sat_counts[3:0]); end
        checks++; if (sat_counts[7:4] !== 4'd0) begin errors++; $display("FAIL sat_ch1: got %0d expected 0", sat_counts[7:4]); end
        checks++; if (sat_ovf !== 2'b01) begin errors++; $display("FAIL sat_ovf: got %b expected 01", sat_ovf); end
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        checks++; if (sat_fail !== 2'b01) begin errors++; $display("FAIL check_ovf_forces: got %b expected 01", sat_fail); end
`endif
    endtask

    task automatic test_reset_mid();
        int t;
        window_len = 16'd512;
        pulse_start(1'b0, t);
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", done); end
        checks++; if (counts !== 32'd0) begin errors++; $display("FAIL mid_reset_counts: got %h expected 0", counts); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL mid_reset_ovf: got %b expected 00", ovf); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        continuous = 1'b0;
        window_len = 16'd0;
        sat_start = 1'b0;
        sat_len = 16'd0;
`ifdef CLK_EDGE_MONITOR_CHECK_EN
        exp_lo = 16'd120;
        exp_hi = 16'd130;
        sat_exp_lo = 4'd0;
        sat_exp_hi = 4'd15;
`endif
        test_reset();
        test_single_shot();
        test_abort();
        test_zero_len();
        test_start_while_busy();
        test_continuous();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
